// File: rtl/disp_queue.sv
// disp_queue -- multi-slot in-order dispatch queue.
//
// Accepts up to ENQ_W packets per cycle (compacted so that only valid slots
// take entries) and offers the DEQ_W oldest entries to the consumer every
// cycle. The consumer pops a prefix of the offered slots.
//
// Optional feature: define DISP_QUEUE_BYPASS_EN to let packets flow straight
// from the enqueue port to the dequeue port while the queue is empty.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears pointers and count)
//   flush      drop every entry at the next edge; overrides enq/deq
//   enq_valid  per-slot enqueue request
//   enq_pkt    slot i at bits [i*PKT_W +: PKT_W]
//   enq_ready  at least ENQ_W free entries (from registered count)
//   deq_valid  slot i holds the i-th oldest entry
//   deq_pkt    dequeue packets, oldest in slot 0
//   deq_ready  per-slot consumer acceptance; only a leading run of ones pops
//   count      registered occupancy
module disp_queue #(
   parameter int DEPTH = 16,
   parameter int ENQ_W = 2,
   parameter int DEQ_W = 2,
   parameter int PKT_W = 92
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [ENQ_W-1:0]           enq_valid,
   input  logic [ENQ_W*PKT_W-1:0]     enq_pkt,
   output logic                       enq_ready,
   output logic [DEQ_W-1:0]           deq_valid,
   output logic [DEQ_W*PKT_W-1:0]     deq_pkt,
   input  logic [DEQ_W-1:0]           deq_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int EN_W  = $clog2(ENQ_W + 1);
   localparam int DN_W  = $clog2(DEQ_W + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ENQ_W_C = CNT_W'(ENQ_W);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Storage is deliberately not reset; deq_pkt is ignored while invalid.
   logic [PKT_W-1:0] mem_q [DEPTH];

   logic [EN_W-1:0]  enq_pos_s [ENQ_W];
   logic [EN_W-1:0]  cmp_n_s;
   logic [EN_W-1:0]  enq_n_s;
   logic [PKT_W-1:0] cmp_pkt_s [ENQ_W];
   logic [DN_W-1:0]  deq_n_s;
   logic [DN_W-1:0]  skip_n_s;
   logic             run_s;
   logic             byp_s;
   logic             wr_en_s  [ENQ_W];
   logic [PTR_W-1:0] wr_idx_s [ENQ_W];

   assign count     = count_q;
   assign enq_ready = (DEPTH_C - count_q) >= ENQ_W_C;
   assign enq_n_s   = enq_ready ? cmp_n_s : {EN_W{1'b0}};

`ifdef DISP_QUEUE_BYPASS_EN
   assign byp_s = (count_q == {CNT_W{1'b0}}) && !flush;
`else
   assign byp_s = 1'b0;
`endif

   // Squeeze valid enqueue slots into a dense, slot-ordered list.
   always_comb begin
      cmp_n_s = {EN_W{1'b0}};
      for (int i = 0; i < ENQ_W; i++) begin
         enq_pos_s[i] = cmp_n_s;
         if (enq_valid[i]) begin
            cmp_n_s = cmp_n_s + EN_W'(1);
         end else begin
            cmp_n_s = cmp_n_s;
         end
      end
      for (int j = 0; j < ENQ_W; j++) begin
         cmp_pkt_s[j] = {PKT_W{1'b0}};
         for (int i = 0; i < ENQ_W; i++) begin
            if (enq_valid[i] && (enq_pos_s[i] == EN_W'(j))) begin
               cmp_pkt_s[j] = enq_pkt[i*PKT_W +: PKT_W];
            end else begin
               cmp_pkt_s[j] = cmp_pkt_s[j];
            end
         end
      end
   end

   // Present the oldest entries (or the bypassed packets when empty).
   always_comb begin
      for (int i = 0; i < DEQ_W; i++) begin
         deq_valid[i]               = (int'(count_q) > i);
         deq_pkt[i*PKT_W +: PKT_W]  = mem_q[head_q + PTR_W'(i)];
      end
`ifdef DISP_QUEUE_BYPASS_EN
      for (int i = 0; i < DEQ_W; i++) begin
         deq_valid[i] = byp_s ? (int'(cmp_n_s) > i) : (int'(count_q) > i);
      end
      for (int i = 0; (i < DEQ_W) && (i < ENQ_W); i++) begin
         deq_pkt[i*PKT_W +: PKT_W] = byp_s ? cmp_pkt_s[i]
                                           : mem_q[head_q + PTR_W'(i)];
      end
`endif
   end

   // Pop count is the leading run of accepted slots starting at slot 0.
   always_comb begin
      deq_n_s = {DN_W{1'b0}};
      run_s   = 1'b1;
      for (int i = 0; i < DEQ_W; i++) begin
         if (run_s && deq_valid[i] && deq_ready[i]) begin
            deq_n_s = deq_n_s + DN_W'(1);
         end else begin
            run_s = 1'b0;
         end
      end
   end

   // Bypassed packets that were popped never occupy an entry.
   assign skip_n_s = byp_s ? deq_n_s : {DN_W{1'b0}};

   // Next pointers and occupancy; flush wins over any traffic.
   always_comb begin
      if (flush) begin
         count_d = {CNT_W{1'b0}};
         head_d  = {PTR_W{1'b0}};
         tail_d  = {PTR_W{1'b0}};
      end else begin
         count_d = count_q + CNT_W'(enq_n_s) - CNT_W'(deq_n_s);
         head_d  = head_q + PTR_W'(deq_n_s) - PTR_W'(skip_n_s);
         tail_d  = tail_q + PTR_W'(enq_n_s) - PTR_W'(skip_n_s);
      end
   end

   // Write ports: compacted packet j lands at tail + (j - skipped).
   always_comb begin
      for (int j = 0; j < ENQ_W; j++) begin
         wr_en_s[j]  = !flush && (j >= int'(skip_n_s)) && (j < int'(enq_n_s));
         wr_idx_s[j] = tail_q + PTR_W'(j) - PTR_W'(skip_n_s);
      end
   end

   // Storage array update.
   always_ff @(posedge clk) begin
      for (int j = 0; j < ENQ_W; j++) begin
         if (wr_en_s[j]) begin
            mem_q[wr_idx_s[j]] <= cmp_pkt_s[j];
         end
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= {PTR_W{1'b0}};
         tail_q  <= {PTR_W{1'b0}};
         count_q <= {CNT_W{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_disp_queue.sv
module tb_disp_queue;
   localparam int PKT_W = 92;
   localparam int DEPTH = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic [1:0]           enq_valid;
   logic [2*PKT_W-1:0]   enq_pkt;
   logic                 enq_ready;
   logic [1:0]           deq_valid;
   logic [2*PKT_W-1:0]   deq_pkt;
   logic [1:0]           deq_ready;
   logic [4:0]           count;

   int checks   = 0;
   int failures = 0;

   // Reference model: the queue contents, oldest first.
   logic [PKT_W-1:0] mq[$];

   disp_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_pkt(enq_pkt), .enq_ready(enq_ready),
      .deq_valid(deq_valid), .deq_pkt(deq_pkt), .deq_ready(deq_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [PKT_W-1:0] rp();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[PKT_W-1:0];
   endfunction

   // One clock cycle: drive, check outputs against model, advance model.
   task automatic step(input logic [1:0] ev, input logic [PKT_W-1:0] p0,
                       input logic [PKT_W-1:0] p1, input logic [1:0] dr,
                       input logic fl);
      logic [PKT_W-1:0] acc[$];
      logic [PKT_W-1:0] vis[$];
      int n;
      enq_valid = ev;
      enq_pkt   = {p1, p0};
      deq_ready = dr;
      flush     = fl;
      #2;
      acc = {};
      if (ev[0]) acc.push_back(p0);
      if (ev[1]) acc.push_back(p1);
      vis = mq;
`ifdef DISP_QUEUE_BYPASS_EN
      if (mq.size() == 0 && !fl) vis = acc;
`endif
      chk("count", count, mq.size());
      chk("enq_ready", enq_ready, (DEPTH - mq.size()) >= 2);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("deq_valid%0d", i), deq_valid[i], i < vis.size());
         if (i < vis.size())
            chk($sformatf("deq_pkt%0d", i), deq_pkt[i*PKT_W +: PKT_W], vis[i]);
      end
      n = 0;
      for (int i = 0; i < 2; i++) begin
         if (i < vis.size() && dr[i]) n++;
         else break;
      end
      if (fl) begin
         mq.delete();
      end else begin
         if ((DEPTH - mq.size()) >= 2) mq = {mq, acc};
         repeat (n) void'(mq.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(2'b00, '0, '0, 2'b00, 1'b0);
   endtask

   // Asynchronous reset pulse in the middle of a cycle.
   task automatic rst_pulse();
      enq_valid = 2'b00;
      deq_ready = 2'b00;
      flush     = 1'b0;
      rst       = 1'b1;
      #1;
      chk("rst_count", count, 0);
      chk("rst_deq_valid", deq_valid, 2'b00);
      chk("rst_enq_ready", enq_ready, 1'b1);
      mq.delete();
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [PKT_W-1:0] a, b, c;
      rst       = 1'b1;
      flush     = 1'b0;
      enq_valid = 2'b00;
      deq_ready = 2'b00;
      enq_pkt   = '0;
      #2;
      chk("reset_count", count, 0);
      chk("reset_enq_ready", enq_ready, 1'b1);
      chk("reset_deq_valid", deq_valid, 2'b00);
      #10 rst = 1'b0;
      @(posedge clk);
      #1;

      // Two packets in one cycle, visible next cycle in order.
      a = rp(); b = rp(); c = rp();
      step(2'b11, a, b, 2'b00, 1'b0);
      step(2'b10, rp(), c, 2'b00, 1'b0);  // compaction: only slot 1 valid
      // count=3: non-prefix ready pops nothing, then single pop.
      step(2'b00, '0, '0, 2'b10, 1'b0);
      step(2'b00, '0, '0, 2'b01, 1'b0);
      idle();

      // Fill to 16, then attempt overrun.
      step(2'b00, '0, '0, 2'b00, 1'b1);
      for (int k = 0; k < 8; k++) step(2'b11, rp(), rp(), 2'b00, 1'b0);
      for (int k = 0; k < 3; k++) step(2'b11, rp(), rp(), 2'b00, 1'b0);
      idle();

      // Move head to 14, refill to 15, then enqueue and dequeue across the wrap.
      step(2'b00, '0, '0, 2'b00, 1'b1);
      for (int k = 0; k < 7; k++) step(2'b11, rp(), rp(), 2'b00, 1'b0);
      for (int k = 0; k < 7; k++) step(2'b00, '0, '0, 2'b11, 1'b0);
      for (int k = 0; k < 7; k++) step(2'b11, rp(), rp(), 2'b00, 1'b0);
      step(2'b01, rp(), rp(), 2'b00, 1'b0);
      step(2'b01, rp(), rp(), 2'b11, 1'b0);
      for (int k = 0; k < 7; k++) step(2'b00, '0, '0, 2'b11, 1'b0);
      idle();

      // Flush overriding simultaneous traffic at count=8.
      for (int k = 0; k < 4; k++) step(2'b11, rp(), rp(), 2'b00, 1'b0);
      step(2'b11, rp(), rp(), 2'b11, 1'b1);
      idle();

      // Reset mid-traffic, then first enqueue after reset.
      for (int k = 0; k < 6; k++) step(2'b11, rp(), rp(), 2'b01, 1'b0);
      rst_pulse();
      step(2'b01, a, rp(), 2'b00, 1'b0);
      idle();

`ifdef DISP_QUEUE_BYPASS_EN
      // Empty-queue bypass: slot0 popped same cycle, slot1 stored.
      step(2'b00, '0, '0, 2'b00, 1'b1);
      step(2'b11, a, b, 2'b01, 1'b0);
      idle();
`endif

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         step(2'($urandom()), rp(), rp(), 2'($urandom()), ($urandom_range(0, 31) == 0));
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
